// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: redirect control, instruction-memory request/response,
// and the instruction handoff toward the read stage.
interface fetch_stage_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  fetch_en;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-3:0] redirect_addr;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-3:0] mem_req_addr;
    logic                  mem_rsp_valid;
    logic [31:0]           mem_rsp_data;
    logic                  insn_valid;
    logic                  insn_ready;
    logic [ADDR_WIDTH-3:0] insn_addr;
    logic [31:0]           insn;

    modport master (
        input  fetch_en, redirect_valid, redirect_addr,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  insn_ready,
        output mem_req_valid, mem_req_addr,
        output insn_valid, insn_addr, insn
    );

    modport slave (
        output fetch_en, redirect_valid, redirect_addr,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output insn_ready,
        input  mem_req_valid, mem_req_addr,
        input  insn_valid, insn_addr, insn
    );
endinterface

// File: rtl/fetch_stage.sv
// In-order instruction fetch with credit-limited request issue and redirect squash.
// Define FETCH_TRACE_EN to print delivered instructions and redirects in simulation.
module fetch_stage #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
    parameter int                    DEPTH      = 4
) (
    input logic           clk,
    input logic           rst,
    fetch_stage_if.master bus
);
    localparam int PW = ADDR_WIDTH - 2;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(2 * DEPTH) + 1;
    localparam logic [CW:0] CAP  = (CW+1)'(DEPTH);
    localparam logic [SW:0] SMAX = (SW+1)'(2 * DEPTH);

    logic [PW-1:0] pc;
    logic [PW-1:0] af_q [DEPTH];
    logic [AW-1:0] af_wp, af_rp;
    logic [CW-1:0] outstanding;
    logic [PW-1:0] bf_addr [DEPTH];
    logic [31:0]   bf_data [DEPTH];
    logic [AW-1:0] bf_wp, bf_rp;
    logic [CW-1:0] buffered;
    logic [SW-1:0] squash;

    logic          pop;
    logic          req_fire;
    logic          rsp_take;
    logic          rsp_drop;
    logic [CW:0]   used_after;
    logic [SW:0]   squash_sum;
    logic [SW-1:0] squash_redir;

    always_comb begin
        pop        = bus.insn_valid & bus.insn_ready;
        used_after = {1'b0, outstanding} + {1'b0, buffered}
                   - {{CW{1'b0}}, pop};
        req_fire   = bus.mem_req_valid & bus.mem_req_ready;
        rsp_take   = bus.mem_rsp_valid & (squash == '0)
                   & !bus.redirect_valid;
        rsp_drop   = bus.mem_rsp_valid & (squash != '0)
                   & !bus.redirect_valid;
        // any response landing in a redirect cycle is dropped against the total
        squash_sum = {1'b0, squash} + (SW+1)'(outstanding)
                   - (SW+1)'(bus.mem_rsp_valid);
        squash_redir = (squash_sum > SMAX) ? SMAX[SW-1:0]
                                           : squash_sum[SW-1:0];
    end

    assign bus.mem_req_valid = !rst & bus.fetch_en & !bus.redirect_valid
                             & (used_after < CAP);
    assign bus.mem_req_addr  = pc;
    assign bus.insn_valid    = (buffered != '0) & !bus.redirect_valid;
    assign bus.insn_addr     = bf_addr[bf_rp];
    assign bus.insn          = bf_data[bf_rp];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_ADDR[ADDR_WIDTH-1:2];
            af_wp       <= '0;
            af_rp       <= '0;
            bf_wp       <= '0;
            bf_rp       <= '0;
            outstanding <= '0;
            buffered    <= '0;
            squash      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                af_q[i]    <= '0;
                bf_addr[i] <= '0;
                bf_data[i] <= '0;
            end
        end else if (bus.redirect_valid) begin
            pc          <= bus.redirect_addr;
            af_wp       <= '0;
            af_rp       <= '0;
            bf_wp       <= '0;
            bf_rp       <= '0;
            outstanding <= '0;
            buffered    <= '0;
            squash      <= squash_redir;
        end else begin
            if (req_fire) begin
                pc          <= pc + PW'(1);
                af_q[af_wp] <= pc;
                af_wp       <= af_wp + AW'(1);
            end
            if (rsp_take) begin
                af_rp          <= af_rp + AW'(1);
                bf_addr[bf_wp] <= af_q[af_rp];
                bf_data[bf_wp] <= bus.mem_rsp_data;
                bf_wp          <= bf_wp + AW'(1);
            end
            if (rsp_drop) begin
                squash <= squash - SW'(1);
            end
            if (pop) begin
                bf_rp <= bf_rp + AW'(1);
            end
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);
            buffered    <= buffered + CW'(rsp_take) - CW'(pop);
        end
    end

    a_rsp_orphan: assert property (@(posedge clk) disable iff (rst)
        bus.mem_rsp_valid |-> (outstanding != '0 || squash != '0));

    a_buf_overflow: assert property (@(posedge clk) disable iff (rst)
        rsp_take |-> (buffered != CW'(DEPTH) || pop));

`ifdef FETCH_TRACE_EN
    always @(posedge clk) begin
        if (!rst && pop)
            $display("%4t FETCH: addr=%h op=%h", $time,
                     {bus.insn_addr, 2'b00}, bus.insn);
        if (!rst && bus.redirect_valid)
            $display("%4t FETCH: redirect to %h squash=%d", $time,
                     {bus.redirect_addr, 2'b00}, squash_redir);
    end
`else
`endif
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Front-end producer for the read (decode) stage.
- Holds the PC and issues in-order word fetches to instruction memory.
- Buffers returned instruction words and delivers them as insn_valid/insn_addr/insn with downstream backpressure.
- Handles PC redirects by flushing buffered words and squashing in-flight responses.

Parameters:
- ADDR_WIDTH, 32, byte-address width; all addresses are word addresses [ADDR_WIDTH-1:2].
- RESET_ADDR, 32'h0000_0000, byte address of the first fetch; bits [1:0] ignored.
- DEPTH, 4, max (outstanding requests + buffered words); power of 2, >=2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- fetch_en  in  1  permit new memory requests
- redirect_valid  in  1  redirect PC, flush pipeline
- redirect_addr  in  ADDR_WIDTH-2  new word PC
- mem_req_valid  out  1  fetch request
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_WIDTH-2  word address requested
- mem_rsp_valid  in  1  in-order response data valid; no backpressure
- mem_rsp_data  in  32  instruction word
- insn_valid  out  1  instruction available to read stage
- insn_ready  in  1  read stage accepts
- insn_addr  out  ADDR_WIDTH-2  word address of insn
- insn  out  32  instruction word

Behaviour:
- Reset (async, rst=1): pc=RESET_ADDR[ADDR_WIDTH-1:2]; buffer empty; outstanding=0; squash=0; insn_valid=0; mem_req_valid=0; mem_req_addr=pc; insn_addr=0; insn=0.
- Counters:
  - outstanding = requests accepted and not yet responded.
  - used = outstanding + buffered words (excludes squashed responses).
- mem_req_valid = fetch_en & !redirect_valid & (used - pop < DEPTH), where pop = insn_valid & insn_ready. A pop frees a credit in the same cycle. mem_req_addr = pc.
- Request handshake (valid & ready): pc <= pc+1, wrapping modulo 2^(ADDR_WIDTH-2); the address is pushed into an address FIFO.
- Response:
  - If squash>0: squash decrements and data is discarded.
  - Else: data is paired with the FIFO head address and written to the data buffer.
  - Responses only arrive for accepted requests. A response with no outstanding request is illegal (assertion).
- Output: insn_valid = buffer non-empty & !redirect_valid. insn/insn_addr show the buffer head and hold stable while insn_valid & !insn_ready.
- Latency: request accepted cycle N, response N+k, insn_valid at N+k+1 (registered buffer). No write-to-read bypass.
- Throughput: with k=1 and DEPTH>=3, one insn per cycle sustained.
- Redirect (single cycle, at the edge):
  - pc <= redirect_addr.
  - Buffer and address FIFO are cleared.
  - squash <= outstanding, minus 1 if a non-squashed response arrives this cycle (that response is also dropped).
  - outstanding <= 0.
  - No request and no pop in the redirect cycle. First new request is issued the next cycle.
- Redirect while squash>0: squash accumulates existing squash + outstanding, saturating at DEPTH+DEPTH (counter width clog2(2*DEPTH)+1).
- fetch_en=0: no new requests; outstanding responses still land and drain; pc frozen.
- Buffer full: cannot occur by credit rule. Overflow is a bug (assertion).
- Simultaneous push and pop on the buffer in one cycle are both performed.
- Reset mid-operation: all state cleared immediately. Responses to pre-reset requests are illegal stimulus; the memory is reset together with this block.

Optional Feature:
- Macro: FETCH_TRACE_EN.
- Defined: on every insn_valid & insn_ready edge (not during rst), prints "%4t FETCH: addr=%h op=%h" with the byte address {insn_addr,2'b00}. Each redirect prints "%4t FETCH: redirect to %h squash=%d". Simulation only, no logic change.
- Undefined: no display code; identical RTL behaviour.

Test Plan:
- Reset with RESET_ADDR=32'h100, fetch_en=1, 1-cycle memory returning data=addr:
  - first mem_req_addr=0x40 (word);
  - insn_valid 2 cycles after the first request, insn_addr=0x40, 0x41, 0x42... one per cycle.
- insn_ready=0 held for 10 cycles with DEPTH=4:
  - exactly 4 requests issued, mem_req_valid then stays low;
  - insn holds head 0x40;
  - after release, words 0x40..0x43 delivered back-to-back, then fetching resumes at 0x44.
- 3-cycle memory latency, redirect_valid with redirect_addr=0x200 while 3 requests are outstanding:
  - the 3 stale responses are dropped;
  - next delivered insn_addr=0x200;
  - no insn_valid in the redirect cycle.
- Redirect in the same cycle as a response and as insn_ready=1:
  - no pop, response dropped;
  - next delivered address = redirect target.
- pc=0x3FFF_FFFF (ADDR_WIDTH=32): next request address is 0x0000_0000 with no stall.
- fetch_en deasserted with 2 outstanding: no new requests; both words are delivered; pc stays fixed until fetch_en=1.
